bcd_display_seq: RTL

//   Parametrised, sequential signed-binary-to-7-segment display driver. Accepts a

---
 rtl/bcd_display_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/bcd_display_seq.sv
// Sequential signed-binary to 7-segment driver: shift-add-3 conversion of |in|,
// one bit per clock, then an atomic update of the held digits, sign and overflow.
module bcd_display_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter bit LZB    = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in,
  input  logic                  start,
  input  logic                  cu_showDisplay,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  negative,
  output logic                  overflow,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_DONE} state_t;

  state_t              state_reg, state_next;
  logic [BW-1:0]       bcd_reg, bcd_next;
  logic [WIDTH-1:0]    mag_reg, mag_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic                sign_reg, sign_next;
  logic                ovf_reg, ovf_next;
  logic [7*DIGITS-1:0] held_seg_reg, held_seg_next;
  logic                negative_reg, negative_next;
  logic                overflow_reg, overflow_next;
  logic                done_reg, done_next;

  logic [BW-1:0]       bcd_adj;
  logic [7*DIGITS-1:0] disp_seg;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h40;
      4'd1:    seg_of = 7'h79;
      4'd2:    seg_of = 7'h24;
      4'd3:    seg_of = 7'h30;
      4'd4:    seg_of = 7'h19;
      4'd5:    seg_of = 7'h12;
      4'd6:    seg_of = 7'h02;
      4'd7:    seg_of = 7'h78;
      4'd8:    seg_of = 7'h00;
      4'd9:    seg_of = 7'h10;
      default: seg_of = 7'h7F;
    endcase
  endfunction

  // Per-digit add-3 correction and display encoding of the finished BCD value.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
      if (gi == 0 || !LZB) begin : g_plain
        assign disp_seg[7*gi +: 7] = ovf_reg ? 7'h3F : seg_of(bcd_reg[4*gi +: 4]);
      end else begin : g_lzb
        // A digit stays lit if it or any more significant digit is nonzero.
        logic nz_above;
        assign nz_above = |bcd_reg[BW-1:4*gi];
        assign disp_seg[7*gi +: 7] = ovf_reg ? 7'h3F :
                                     (nz_above ? seg_of(bcd_reg[4*gi +: 4]) : 7'h7F);
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      bcd_reg      <= '0;
      mag_reg      <= '0;
      cnt_reg      <= '0;
      sign_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      held_seg_reg <= '1;
      negative_reg <= 1'b0;
      overflow_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bcd_reg      <= bcd_next;
      mag_reg      <= mag_next;
      cnt_reg      <= cnt_next;
      sign_reg     <= sign_next;
      ovf_reg      <= ovf_next;
      held_seg_reg <= held_seg_next;
      negative_reg <= negative_next;
      overflow_reg <= overflow_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bcd_next      = bcd_reg;
    mag_next      = mag_reg;
    cnt_next      = cnt_reg;
    sign_next     = sign_reg;
    ovf_next      = ovf_reg;
    held_seg_next = held_seg_reg;
    negative_next = negative_reg;
    overflow_next = overflow_reg;
    done_next     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          sign_next  = in[WIDTH-1];
          // Unsigned WIDTH-bit magnitude keeps the most negative value exact.
          mag_next   = in[WIDTH-1] ? (~in + 1'b1) : in;
          bcd_next   = '0;
          ovf_next   = 1'b0;
          cnt_next   = CW'(WIDTH);
          state_next = ST_CONV;
        end
      end
      ST_CONV: begin
        bcd_next = {bcd_adj[BW-2:0], mag_reg[WIDTH-1]};
        mag_next = {mag_reg[WIDTH-2:0], 1'b0};
        ovf_next = ovf_reg | bcd_adj[BW-1];
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CW'(1)) state_next = ST_DONE;
      end
      ST_DONE: begin
        held_seg_next = disp_seg;
        negative_next = sign_reg;
        overflow_next = ovf_reg;
        done_next     = 1'b1;
        state_next    = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign seg      = cu_showDisplay ? held_seg_reg : '1;
  assign negative = negative_reg;
  assign overflow = overflow_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;

endmodule
